// File: rtl/blk_uart_pkg.sv
// Shared encodings for the framed UART transmit path: FSM states, frame field
// selects, default start-of-frame byte and the checksum accumulate helper.
package blk_uart_pkg;

  typedef enum logic [1:0] {
    s_IDLE = 2'd0,
    s_SEND = 2'd1,
    s_WAIT = 2'd2,
    s_FIN  = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    F_SOF = 2'd0,
    F_LEN = 2'd1,
    F_PAY = 2'd2,
    F_CHK = 2'd3
  } field_e;

  localparam logic [7:0] SOF_DEFAULT = 8'hAA;

  // Modulo-256 checksum step; the 8-bit result drops the carry.
  function automatic logic [7:0] chk_add(input logic [7:0] acc, input logic [7:0] b);
    return acc + b;
  endfunction

endpackage

// File: rtl/blk_frame_tx_buf.sv
// Payload buffer for blk_frame_tx: register file with a synchronous write port,
// combinational indexed read, and the buffered-byte count / full flag.
module blk_frame_tx_buf #(
  parameter int MAX_LEN = 16,
  parameter int CW      = 5
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          wr_en_i,
  input  logic [7:0]    wr_data_i,
  input  logic          clr_i,
  input  logic [CW-1:0] rd_idx_i,
  output logic [7:0]    rd_data_o,
  output logic [CW-1:0] count_o,
  output logic          full_o
);

  // Sized to the full count range so any index value selects a real entry.
  localparam int DEPTH = 1 << CW;

  logic [7:0]    mem_q [DEPTH];
  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;
  logic          full_s;
  logic          wr_ok_s;

  // Full flag, write qualification and next count.
  always_comb begin
    full_s  = (count_q == CW'(MAX_LEN));
    wr_ok_s = wr_en_i && !full_s;
    count_d = count_q;
    if (clr_i) begin
      count_d = {CW{1'b0}};
    end else if (wr_ok_s) begin
      count_d = count_q + CW'(1);
    end else begin
      count_d = count_q;
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q <= {CW{1'b0}};
    end else begin
      count_q <= count_d;
    end
  end

  // Payload storage; contents are don't-care after reset.
  always_ff @(posedge clk) begin
    if (wr_ok_s) begin
      mem_q[count_q] <= wr_data_i;
    end
  end

  assign rd_data_o = mem_q[rd_idx_i];
  assign count_o   = count_q;
  assign full_o    = full_s;

endmodule

// File: rtl/blk_frame_tx.sv
// Framed transmit sequencer: emits SOF, LEN, payload and CHK one byte at a time
// over the uart_tx byte handshake, using the buffered payload.
module blk_frame_tx
  import blk_uart_pkg::*;
#(
  parameter int         MAX_LEN = 16,
  parameter logic [7:0] SOF     = SOF_DEFAULT,
  parameter int         CW      = 5
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_wr_en,
  input  logic [7:0]    i_wr_data,
  input  logic          i_start,
  input  logic          i_tx_done,
  output logic          o_tx_dv,
  output logic [7:0]    o_tx_byte,
  output logic          o_busy,
  output logic          o_done,
  output logic          o_wr_full,
  output logic [CW-1:0] o_count
);

  state_e        state_q;
  field_e        field_q;
  logic [CW-1:0] idx_q;
  logic [CW-1:0] len_q;
  logic [7:0]    chk_q;
  logic          tx_dv_q;
  logic [7:0]    tx_byte_q;
  logic          busy_q;
  logic          done_q;

  logic          wr_en_s;
  logic          clr_s;
  logic [CW-1:0] idx_nxt_s;
  logic [CW-1:0] rd_idx_s;
  logic [7:0]    rd_data_s;
  field_e        nxt_field_s;
  logic [7:0]    nxt_byte_s;
  logic [7:0]    nxt_chk_s;
  logic [CW-1:0] nxt_idx_s;

  blk_frame_tx_buf #(
    .MAX_LEN (MAX_LEN),
    .CW      (CW)
  ) u_buf (
    .clk       (clk),
    .reset     (reset),
    .wr_en_i   (wr_en_s),
    .wr_data_i (i_wr_data),
    .clr_i     (clr_s),
    .rd_idx_i  (rd_idx_s),
    .rd_data_o (rd_data_s),
    .count_o   (o_count),
    .full_o    (o_wr_full)
  );

  // Buffer control and the field/byte/checksum that follow the current byte.
  // Start wins over a same-cycle write, so the write is masked by i_start.
  always_comb begin
    wr_en_s     = i_wr_en && (state_q == s_IDLE) && !i_start;
    clr_s       = (state_q == s_FIN);
    idx_nxt_s   = idx_q + CW'(1);
    rd_idx_s    = (field_q == F_PAY) ? idx_nxt_s : {CW{1'b0}};
    nxt_field_s = F_CHK;
    nxt_byte_s  = chk_q;
    nxt_chk_s   = chk_q;
    nxt_idx_s   = idx_q;
    case (field_q)
      F_SOF: begin
        nxt_field_s = F_LEN;
        nxt_byte_s  = 8'(len_q);
        nxt_chk_s   = chk_add(chk_q, 8'(len_q));
      end
      F_LEN: begin
        if (len_q != {CW{1'b0}}) begin
          nxt_field_s = F_PAY;
          nxt_byte_s  = rd_data_s;
          nxt_chk_s   = chk_add(chk_q, rd_data_s);
        end else begin
          nxt_field_s = F_CHK;
          nxt_byte_s  = chk_q;
        end
      end
      F_PAY: begin
        nxt_idx_s = idx_nxt_s;
        if (idx_nxt_s < len_q) begin
          nxt_field_s = F_PAY;
          nxt_byte_s  = rd_data_s;
          nxt_chk_s   = chk_add(chk_q, rd_data_s);
        end else begin
          nxt_field_s = F_CHK;
          nxt_byte_s  = chk_q;
        end
      end
      F_CHK: begin
        nxt_field_s = F_CHK;
      end
      default: begin
        nxt_field_s = F_CHK;
      end
    endcase
  end

  // Frame FSM; the strobe and byte are registered on entry to SEND so they
  // appear the cycle after start or i_tx_done.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= s_IDLE;
      field_q   <= F_SOF;
      idx_q     <= {CW{1'b0}};
      len_q     <= {CW{1'b0}};
      chk_q     <= 8'h00;
      tx_dv_q   <= 1'b0;
      tx_byte_q <= 8'h00;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      case (state_q)
        s_IDLE: begin
          done_q <= 1'b0;
          if (i_start) begin
            state_q   <= s_SEND;
            field_q   <= F_SOF;
            idx_q     <= {CW{1'b0}};
            len_q     <= o_count;
            chk_q     <= 8'h00;
            tx_dv_q   <= 1'b1;
            tx_byte_q <= SOF;
            busy_q    <= 1'b1;
          end else begin
            tx_dv_q <= 1'b0;
          end
        end
        s_SEND: begin
          tx_dv_q <= 1'b0;
          state_q <= s_WAIT;
        end
        s_WAIT: begin
          if (i_tx_done) begin
            if (field_q == F_CHK) begin
              state_q <= s_FIN;
              done_q  <= 1'b1;
              busy_q  <= 1'b0;
            end else begin
              state_q   <= s_SEND;
              field_q   <= nxt_field_s;
              tx_byte_q <= nxt_byte_s;
              chk_q     <= nxt_chk_s;
              idx_q     <= nxt_idx_s;
              tx_dv_q   <= 1'b1;
            end
          end
        end
        s_FIN: begin
          done_q  <= 1'b0;
          state_q <= s_IDLE;
        end
        default: begin
          state_q <= s_IDLE;
          tx_dv_q <= 1'b0;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign o_tx_dv   = tx_dv_q;
  assign o_tx_byte = tx_byte_q;
  assign o_busy    = busy_q;
  assign o_done    = done_q;

endmodule

// File: tb/tb_blk_frame_tx.sv
// Self-checking bench for blk_frame_tx: a uart_tx stand-in acknowledges each
// strobed byte, and each scenario compares captured bytes against its queue.
module tb_blk_frame_tx;

  logic       clk = 1'b0;
  logic       reset;
  logic       i_wr_en;
  logic [7:0] i_wr_data;
  logic       i_start;
  logic       i_tx_done;
  logic       o_tx_dv;
  logic [7:0] o_tx_byte;
  logic       o_busy;
  logic       o_done;
  logic       o_wr_full;
  logic [4:0] o_count;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int done_cnt = 0;
  int done_cyc = -1;
  int txd_cyc = -1;
  logic busy_at_done = 1'b1;
  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];

  blk_frame_tx #(.MAX_LEN(16), .SOF(8'hAA), .CW(5)) dut (
    .clk       (clk),
    .reset     (reset),
    .i_wr_en   (i_wr_en),
    .i_wr_data (i_wr_data),
    .i_start   (i_start),
    .i_tx_done (i_tx_done),
    .o_tx_dv   (o_tx_dv),
    .o_tx_byte (o_tx_byte),
    .o_busy    (o_busy),
    .o_done    (o_done),
    .o_wr_full (o_wr_full),
    .o_count   (o_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: capture strobed bytes and done timing mid-cycle.
  always @(negedge clk) begin
    if (o_tx_dv === 1'b1) got_q.push_back(o_tx_byte);
    if (i_tx_done === 1'b1) txd_cyc = cyc;
    if (o_done === 1'b1) begin
      done_cnt = done_cnt + 1;
      done_cyc = cyc;
      busy_at_done = o_busy;
    end
  end

  // uart_tx stand-in: pulse i_tx_done three cycles after each strobe.
  initial begin
    i_tx_done = 1'b0;
    forever begin
      @(negedge clk);
      if (o_tx_dv === 1'b1) begin
        repeat (3) @(posedge clk);
        #1 i_tx_done = 1'b1;
        @(posedge clk);
        #1 i_tx_done = 1'b0;
      end
    end
  end

  task automatic write_byte(input logic [7:0] d);
    i_wr_en = 1'b1;
    i_wr_data = d;
    @(posedge clk);
    #1 i_wr_en = 1'b0;
  endtask

  task automatic pulse_start();
    i_start = 1'b1;
    @(posedge clk);
    #1 i_start = 1'b0;
  endtask

  task automatic wait_done(output bit ok);
    int base;
    base = done_cnt;
    ok = 1'b0;
    for (int k = 0; k < 400; k++) begin
      @(posedge clk);
      #1;
      if (done_cnt != base) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    i_wr_en = 1'b0;
    i_wr_data = 8'h00;
    i_start = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({o_tx_dv, o_busy, o_done, o_wr_full, o_count, o_tx_byte} !== 17'h0) begin
      errors++;
      $display("FAIL reset_outputs got dv=%b busy=%b done=%b full=%b cnt=%0d byte=%h required all 0",
               o_tx_dv, o_busy, o_done, o_wr_full, o_count, o_tx_byte);
    end
    @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_basic();
    bit ok;
    int d0;
    logic [7:0] e, g;
    write_byte(8'h01); write_byte(8'h02); write_byte(8'h03);
    checks++;
    if (o_count !== 5'd3) begin
      errors++; $display("FAIL basic_count got=%0d required=3", o_count);
    end
    exp_q = '{8'hAA, 8'h03, 8'h01, 8'h02, 8'h03, 8'h09};
    d0 = done_cnt;
    pulse_start();
    wait_done(ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL basic_timeout got=no o_done required=o_done"); end
    checks++;
    if (got_q.size() != exp_q.size()) begin
      errors++; $display("FAIL basic_nbytes got=%0d required=%0d", got_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front();
      checks++;
      if (g !== e) begin errors++; $display("FAIL basic_byte got=%h required=%h", g, e); end
    end
    repeat (5) @(posedge clk);
    #1;
    checks++;
    if (done_cnt - d0 != 1) begin
      errors++; $display("FAIL basic_done_count got=%0d required=1", done_cnt - d0);
    end
    checks++;
    if (o_count !== 5'd0) begin errors++; $display("FAIL basic_count_after got=%0d required=0", o_count); end
    exp_q.delete(); got_q.delete();
  endtask

  task automatic test_empty();
    bit ok;
    int n;
    logic [7:0] e, g;
    exp_q = '{8'hAA, 8'h00, 8'h00};
    i_start = 1'b1;
    @(negedge clk);
    n = cyc;
    @(posedge clk);
    #1 i_start = 1'b0;
    @(negedge clk);
    checks++;
    if (o_tx_dv !== 1'b1 || o_busy !== 1'b1 || cyc != n + 1) begin
      errors++; $display("FAIL empty_start_latency got dv=%b busy=%b dcyc=%0d required dv=1 busy=1 dcyc=1",
                         o_tx_dv, o_busy, cyc - n);
    end
    wait_done(ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL empty_timeout got=no o_done required=o_done"); end
    checks++;
    if (done_cyc != txd_cyc + 1 || busy_at_done !== 1'b0) begin
      errors++; $display("FAIL empty_done_timing got dcyc=%0d busy=%b required dcyc=1 busy=0",
                         done_cyc - txd_cyc, busy_at_done);
    end
    checks++;
    if (got_q.size() != exp_q.size()) begin
      errors++; $display("FAIL empty_nbytes got=%0d required=%0d", got_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front();
      checks++;
      if (g !== e) begin errors++; $display("FAIL empty_byte got=%h required=%h", g, e); end
    end
    exp_q.delete(); got_q.delete();
  endtask

  task automatic test_full();
    bit ok;
    logic [7:0] e, g;
    for (int i = 0; i < 16; i++) write_byte(8'hFF);
    checks++;
    if (o_wr_full !== 1'b1 || o_count !== 5'd16) begin
      errors++; $display("FAIL full_flag got full=%b cnt=%0d required full=1 cnt=16", o_wr_full, o_count);
    end
    write_byte(8'hFF);
    checks++;
    if (o_count !== 5'd16) begin errors++; $display("FAIL full_drop got=%0d required=16", o_count); end
    exp_q.push_back(8'hAA);
    exp_q.push_back(8'h10);
    for (int i = 0; i < 16; i++) exp_q.push_back(8'hFF);
    exp_q.push_back(8'h00);
    pulse_start();
    wait_done(ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL full_timeout got=no o_done required=o_done"); end
    checks++;
    if (got_q.size() != exp_q.size()) begin
      errors++; $display("FAIL full_nbytes got=%0d required=%0d", got_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front();
      checks++;
      if (g !== e) begin errors++; $display("FAIL full_byte got=%h required=%h", g, e); end
    end
    exp_q.delete(); got_q.delete();
  endtask

  task automatic test_busy_ignore();
    bit ok;
    bit seen;
    int d0;
    logic [7:0] e, g;
    write_byte(8'h01); write_byte(8'h02); write_byte(8'h03);
    exp_q = '{8'hAA, 8'h03, 8'h01, 8'h02, 8'h03, 8'h09};
    d0 = done_cnt;
    pulse_start();
    seen = 1'b0;
    for (int k = 0; k < 200; k++) begin
      if (got_q.size() >= 4) begin seen = 1'b1; break; end
      @(posedge clk);
      #1;
    end
    checks++;
    if (!seen) begin errors++; $display("FAIL busy_wait_timeout got=%0d bytes required=4", got_q.size()); end
    i_start = 1'b1; i_wr_en = 1'b1; i_wr_data = 8'h55;
    @(posedge clk);
    #1 i_start = 1'b0; i_wr_en = 1'b0;
    checks++;
    if (o_count !== 5'd3) begin errors++; $display("FAIL busy_count got=%0d required=3", o_count); end
    wait_done(ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL busy_timeout got=no o_done required=o_done"); end
    repeat (20) @(posedge clk);
    #1;
    checks++;
    if (got_q.size() != exp_q.size() || done_cnt - d0 != 1) begin
      errors++; $display("FAIL busy_extra got bytes=%0d dones=%0d required bytes=%0d dones=1",
                         got_q.size(), done_cnt - d0, exp_q.size());
    end
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front();
      checks++;
      if (g !== e) begin errors++; $display("FAIL busy_byte got=%h required=%h", g, e); end
    end
    exp_q.delete(); got_q.delete();
  endtask

  task automatic test_start_wins();
    bit ok;
    logic [7:0] e, g;
    write_byte(8'h10); write_byte(8'h20);
    exp_q = '{8'hAA, 8'h02, 8'h10, 8'h20, 8'h32};
    i_start = 1'b1; i_wr_en = 1'b1; i_wr_data = 8'h77;
    @(posedge clk);
    #1 i_start = 1'b0; i_wr_en = 1'b0;
    wait_done(ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL wins_timeout got=no o_done required=o_done"); end
    checks++;
    if (got_q.size() != exp_q.size()) begin
      errors++; $display("FAIL wins_nbytes got=%0d required=%0d", got_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front();
      checks++;
      if (g !== e) begin errors++; $display("FAIL wins_byte got=%h required=%h", g, e); end
    end
    exp_q.delete(); got_q.delete();
  endtask

  task automatic test_reset_mid();
    bit ok;
    bit seen;
    int d0;
    logic [7:0] e, g;
    write_byte(8'h11); write_byte(8'h22);
    exp_q = '{8'hAA, 8'h02};
    d0 = done_cnt;
    pulse_start();
    seen = 1'b0;
    for (int k = 0; k < 200; k++) begin
      if (got_q.size() >= 2) begin seen = 1'b1; break; end
      @(posedge clk);
      #1;
    end
    checks++;
    if (!seen) begin errors++; $display("FAIL rmid_wait_timeout got=%0d bytes required=2", got_q.size()); end
    reset = 1'b0;
    #1;
    checks++;
    if (o_busy !== 1'b0 || o_tx_dv !== 1'b0 || o_count !== 5'd0) begin
      errors++; $display("FAIL rmid_abort got busy=%b dv=%b cnt=%0d required 0 0 0", o_busy, o_tx_dv, o_count);
    end
    repeat (6) @(posedge clk);
    #1 reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (done_cnt != d0) begin errors++; $display("FAIL rmid_no_done got=%0d required=0", done_cnt - d0); end
    checks++;
    if (got_q.size() != exp_q.size()) begin
      errors++; $display("FAIL rmid_nbytes got=%0d required=%0d", got_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front();
      checks++;
      if (g !== e) begin errors++; $display("FAIL rmid_byte got=%h required=%h", g, e); end
    end
    exp_q.delete(); got_q.delete();
    exp_q = '{8'hAA, 8'h00, 8'h00};
    pulse_start();
    wait_done(ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL rmid_restart_timeout got=no o_done required=o_done"); end
    checks++;
    if (got_q.size() != exp_q.size()) begin
      errors++; $display("FAIL rmid_restart_nbytes got=%0d required=%0d", got_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front();
      checks++;
      if (g !== e) begin errors++; $display("FAIL rmid_restart_byte got=%h required=%h", g, e); end
    end
    exp_q.delete(); got_q.delete();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_empty();
    test_full();
    test_busy_ignore();
    test_start_wins();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
